data_read_unit: RTL and testbench

DATA_READ_UNIT -- requirements
Module: data_read_unit

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/data_read_unit_if.sv | 23 ++
 rtl/llsc_reservation.sv | 62 ++++++
 rtl/data_read_unit.sv | 117 +++++++++++
 tb/tb_data_read_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-read path: FSM encoding and
// the word-address width.
package mips_mem_pkg;

  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } drd_state_e;

endpackage

// File: rtl/data_read_unit_if.sv
// Data-memory read bus between the read unit (master) and memory (slave).
// Handshake: the master raises DataMem_Read and holds it, together with a
// stable DataMem_Address, until the cycle in which the slave pulses
// DataMem_Ack; DataMem_ReadData is valid only in that Ack cycle. A request
// is never withdrawn before its Ack.
interface data_read_unit_if;
  import mips_mem_pkg::*;

  logic                   DataMem_Read;
  logic [WORD_ADDR_W-1:0] DataMem_Address;
  logic                   DataMem_Ack;
  logic [31:0]            DataMem_ReadData;

  modport master (
    output DataMem_Read, DataMem_Address,
    input  DataMem_Ack, DataMem_ReadData
  );

  modport slave (
    input  DataMem_Read, DataMem_Address,
    output DataMem_Ack, DataMem_ReadData
  );
endinterface

// File: rtl/llsc_reservation.sv
// LL/SC reservation: tracks an in-flight LL, sets LLbit/LLAddr when its data
// is captured, and clears on ERET, SC completion or a matching invalidation.
// A clear arriving together with (or ahead of) the capture wins.
module llsc_reservation
  import mips_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_is_ll,
  input  logic                   capture,
  input  logic [WORD_ADDR_W-1:0] fill_addr,
  input  logic [WORD_ADDR_W-1:0] cur_addr,
  input  logic                   eret,
  input  logic                   sc_done,
  input  logic                   inval_valid,
  input  logic [WORD_ADDR_W-1:0] inval_addr,
  output logic                   atomic
);

  logic                   ll_pend;
  logic                   ll_dead;
  logic                   ll_bit;
  logic [WORD_ADDR_W-1:0] ll_addr;
  logic                   hit_fill;
  logic                   hit_res;
  logic                   clear_any;

  assign hit_fill  = inval_valid && (inval_addr == fill_addr);
  assign hit_res   = inval_valid && (inval_addr == ll_addr);
  assign clear_any = eret || sc_done || hit_res;

  // Remember whether the in-flight load is an LL and whether its word was
  // invalidated while the read was outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ll_pend <= 1'b0;
      ll_dead <= 1'b0;
    end else if (load_start) begin
      ll_pend <= load_is_ll;
      ll_dead <= 1'b0;
    end else if (hit_fill) begin
      ll_dead <= 1'b1;
    end
  end

  // Reservation register: LL capture arms it unless killed, clears drop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ll_bit  <= 1'b0;
      ll_addr <= '0;
    end else if (capture && ll_pend) begin
      ll_addr <= fill_addr;
      ll_bit  <= !(eret || sc_done || hit_fill || ll_dead);
    end else if (clear_any) begin
      ll_bit <= 1'b0;
    end
  end

  assign atomic = ll_bit && (ll_addr == cur_addr);

endmodule

// File: rtl/data_read_unit.sv
// MEM-stage data-read unit: issues one word read per load, stalls the pipe
// until data returns, drains reads orphaned by a flush, and holds captured
// data while the pipe is stalled downstream.
// Optional macro DATA_READ_LLSC_EN adds the LL/SC reservation; without it
// Atomic is tied high so SC behaves as a plain store.
module data_read_unit
  import mips_mem_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Req_Read,
  input  logic                   Req_LL,
  input  logic                   Req_SC,
  input  logic [31:0]            Address,
  input  logic                   Flush,
  input  logic                   Eret,
  input  logic                   Pipe_Stall,
  input  logic                   Inval_Valid,
  input  logic [WORD_ADDR_W-1:0] Inval_Address,
  data_read_unit_if.master       mem,
  output logic [31:0]            ReadData,
  output logic                   Stall,
  output logic                   Atomic,
  output drd_state_e             dbg_state
);

  drd_state_e             state_q;
  drd_state_e             state_d;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [31:0]            rdata_q;
  logic                   accept;
  logic                   capture;

  // Next-state and handshake outputs; Ack is only looked at in WAIT/DRAIN.
  always_comb begin
    state_d          = state_q;
    Stall            = 1'b0;
    mem.DataMem_Read = 1'b0;
    accept           = 1'b0;
    capture          = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req_Read && !Flush) begin
          accept  = 1'b1;
          Stall   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem.DataMem_Read = 1'b1;
        Stall            = 1'b1;
        if (mem.DataMem_Ack) begin
          if (!Flush) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else if (Flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem.DataMem_Read = 1'b1;
        Stall            = 1'b1;
        if (mem.DataMem_Ack) state_d = IDLE;
      end
      DONE: begin
        if (!Pipe_Stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request address and captured data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)  addr_q  <= Address[31:2];
      if (capture) rdata_q <= mem.DataMem_ReadData;
    end
  end

  assign mem.DataMem_Address = addr_q;
  assign ReadData            = rdata_q;
  assign dbg_state           = state_q;

`ifdef DATA_READ_LLSC_EN
  logic unused_bits;
  assign unused_bits = ^Address[1:0];

  llsc_reservation u_llsc (
    .clk         (clock),
    .rst         (reset),
    .load_start  (accept),
    .load_is_ll  (Req_LL),
    .capture     (capture),
    .fill_addr   (addr_q),
    .cur_addr    (Address[31:2]),
    .eret        (Eret),
    .sc_done     (Req_SC),
    .inval_valid (Inval_Valid),
    .inval_addr  (Inval_Address),
    .atomic      (Atomic)
  );
`else
  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Req_LL, Req_SC, Eret, Inval_Valid, Inval_Address};

  assign Atomic = 1'b1;
`endif

endmodule

// File: tb/tb_data_read_unit.sv
// Directed bench for data_read_unit: load latency, flush/drain, downstream
// stall hold, reset abort, stray acks and (when DATA_READ_LLSC_EN is
// defined) LL/SC reservation behaviour.
module tb_data_read_unit;
  import mips_mem_pkg::*;

  logic                   clock;
  logic                   reset;
  logic                   Req_Read;
  logic                   Req_LL;
  logic                   Req_SC;
  logic [31:0]            Address;
  logic                   Flush;
  logic                   Eret;
  logic                   Pipe_Stall;
  logic                   Inval_Valid;
  logic [WORD_ADDR_W-1:0] Inval_Address;
  logic [31:0]            ReadData;
  logic                   Stall;
  logic                   Atomic;
  drd_state_e             dbg_state;

  int n_cmp;
  int n_err;

  data_read_unit_if mem_if ();

  data_read_unit dut (
    .clock         (clock),
    .reset         (reset),
    .Req_Read      (Req_Read),
    .Req_LL        (Req_LL),
    .Req_SC        (Req_SC),
    .Address       (Address),
    .Flush         (Flush),
    .Eret          (Eret),
    .Pipe_Stall    (Pipe_Stall),
    .Inval_Valid   (Inval_Valid),
    .Inval_Address (Inval_Address),
    .mem           (mem_if.master),
    .ReadData      (ReadData),
    .Stall         (Stall),
    .Atomic        (Atomic),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Req_Read                = 1'b0;
    Req_LL                  = 1'b0;
    Req_SC                  = 1'b0;
    Address                 = 32'h0;
    Flush                   = 1'b0;
    Eret                    = 1'b0;
    Pipe_Stall              = 1'b0;
    Inval_Valid             = 1'b0;
    Inval_Address           = '0;
    mem_if.DataMem_Ack      = 1'b0;
    mem_if.DataMem_ReadData = 32'h0;
  endtask

  // Full load: request, optional invalidation in WAIT, Ack (optionally with
  // ERET in the same cycle), then one DONE cycle back to IDLE.
  task automatic run_load(input logic [31:0] a, input logic ll, input logic [31:0] d,
                          input logic eret_at_ack, input logic inval_in_wait);
    Req_Read = 1'b1;
    Req_LL   = ll;
    Address  = a;
    tick();
    if (inval_in_wait) begin
      Inval_Valid   = 1'b1;
      Inval_Address = a[31:2];
      tick();
      Inval_Valid = 1'b0;
    end
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = d;
    Eret                    = eret_at_ack;
    tick();
    mem_if.DataMem_Ack = 1'b0;
    Eret               = 1'b0;
    Req_Read           = 1'b0;
    Req_LL             = 1'b0;
    tick();
  endtask

`ifdef DATA_READ_LLSC_EN
  localparam logic [31:0] ATOMIC_RST = 32'd0;
`else
  localparam logic [31:0] ATOMIC_RST = 32'd1;
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    check_val("rst_read",  32'(mem_if.DataMem_Read), 32'd0);
    check_val("rst_addr",  32'(mem_if.DataMem_Address), 32'd0);
    check_val("rst_rdata", ReadData, 32'd0);
    check_val("rst_stall", 32'(Stall), 32'd0);
    check_val("rst_atomic", 32'(Atomic), ATOMIC_RST);

    // LW 0x1004, Ack on cycle 3
    Req_Read = 1'b1;
    Address  = 32'h0000_1004;
    #1;
    check_val("lw_c0_stall", 32'(Stall), 32'd1);
    check_val("lw_c0_read",  32'(mem_if.DataMem_Read), 32'd0);
    tick();
    check_val("lw_c1_state", 32'(dbg_state), 32'(WAIT));
    check_val("lw_c1_read",  32'(mem_if.DataMem_Read), 32'd1);
    check_val("lw_c1_addr",  32'(mem_if.DataMem_Address), 32'h401);
    check_val("lw_c1_stall", 32'(Stall), 32'd1);
    tick();
    check_val("lw_c2_stall", 32'(Stall), 32'd1);
    check_val("lw_c2_addr",  32'(mem_if.DataMem_Address), 32'h401);
    tick();
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = 32'hDEAD_BEEF;
    #1;
    check_val("lw_c3_stall", 32'(Stall), 32'd1);
    check_val("lw_c3_rdata_old", ReadData, 32'd0);
    tick();
    mem_if.DataMem_Ack      = 1'b0;
    mem_if.DataMem_ReadData = 32'h0;
    #1;
    check_val("lw_c4_rdata", ReadData, 32'hDEAD_BEEF);
    check_val("lw_c4_stall", 32'(Stall), 32'd0);
    check_val("lw_c4_state", 32'(dbg_state), 32'(DONE));
    check_val("lw_c4_read",  32'(mem_if.DataMem_Read), 32'd0);
    tick();
    Req_Read = 1'b0;
    #1;
    check_val("lw_c5_state", 32'(dbg_state), 32'(IDLE));
    check_val("lw_c5_read",  32'(mem_if.DataMem_Read), 32'd0);

    // Flush one cycle after request; Ack two cycles later
    Req_Read = 1'b1;
    Address  = 32'h0000_3008;
    tick();
    Flush = 1'b1;
    #1;
    check_val("fl_c1_stall", 32'(Stall), 32'd1);
    tick();
    Flush    = 1'b0;
    Req_Read = 1'b0;
    #1;
    check_val("fl_c2_state", 32'(dbg_state), 32'(DRAIN));
    check_val("fl_c2_read",  32'(mem_if.DataMem_Read), 32'd1);
    check_val("fl_c2_addr",  32'(mem_if.DataMem_Address), 32'hC02);
    check_val("fl_c2_stall", 32'(Stall), 32'd1);
    tick();
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = 32'h1234_5678;
    #1;
    check_val("fl_c3_read", 32'(mem_if.DataMem_Read), 32'd1);
    tick();
    mem_if.DataMem_Ack = 1'b0;
    #1;
    check_val("fl_c4_state", 32'(dbg_state), 32'(IDLE));
    check_val("fl_c4_rdata", ReadData, 32'hDEAD_BEEF);
    check_val("fl_c4_read",  32'(mem_if.DataMem_Read), 32'd0);
    check_val("fl_c4_stall", 32'(Stall), 32'd0);

    // Stray Ack in IDLE
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = 32'hAAAA_AAAA;
    tick();
    mem_if.DataMem_Ack = 1'b0;
    #1;
    check_val("idle_ack_rdata", ReadData, 32'hDEAD_BEEF);
    check_val("idle_ack_state", 32'(dbg_state), 32'(IDLE));

    // Minimum latency, then 3 cycles of downstream stall in DONE
    Req_Read = 1'b1;
    Address  = 32'h0000_0040;
    tick();
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = 32'hCAFE_F00D;
    Pipe_Stall              = 1'b1;
    tick();
    mem_if.DataMem_Ack      = 1'b0;
    mem_if.DataMem_ReadData = 32'h0;
    #1;
    check_val("min_lat_rdata", ReadData, 32'hCAFE_F00D);
    check_val("min_lat_stall", 32'(Stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        mem_if.DataMem_Ack      = 1'b1;
        mem_if.DataMem_ReadData = 32'h5555_5555;
      end
      #1;
      check_val($sformatf("ps_state_%0d", i), 32'(dbg_state), 32'(DONE));
      check_val($sformatf("ps_read_%0d", i),  32'(mem_if.DataMem_Read), 32'd0);
      check_val($sformatf("ps_rdata_%0d", i), ReadData, 32'hCAFE_F00D);
      tick();
      mem_if.DataMem_Ack = 1'b0;
    end
    Pipe_Stall = 1'b0;
    Req_Read   = 1'b0;
    tick();
    check_val("ps_exit_state", 32'(dbg_state), 32'(IDLE));
    check_val("ps_exit_rdata", ReadData, 32'hCAFE_F00D);

    // Reset while in WAIT, then a stray Ack
    Req_Read = 1'b1;
    Address  = 32'h0000_5000;
    tick();
    Req_Read = 1'b0;
    #1;
    check_val("rw_pre_state", 32'(dbg_state), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset                   = 1'b0;
    mem_if.DataMem_Ack      = 1'b1;
    mem_if.DataMem_ReadData = 32'h7777_7777;
    #1;
    check_val("rw_state", 32'(dbg_state), 32'(IDLE));
    check_val("rw_read",  32'(mem_if.DataMem_Read), 32'd0);
    check_val("rw_addr",  32'(mem_if.DataMem_Address), 32'd0);
    check_val("rw_rdata", ReadData, 32'd0);
    check_val("rw_stall", 32'(Stall), 32'd0);
    tick();
    mem_if.DataMem_Ack = 1'b0;
    #1;
    check_val("rw_ack_rdata", ReadData, 32'd0);
    check_val("rw_ack_state", 32'(dbg_state), 32'(IDLE));

`ifdef DATA_READ_LLSC_EN
    // LL 0x2000, SC succeeds once, second SC fails
    run_load(32'h0000_2000, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    Address = 32'h0000_2004;
    #1;
    check_val("ll_other_addr", 32'(Atomic), 32'd0);
    Address = 32'h0000_2000;
    Req_SC  = 1'b1;
    #1;
    check_val("sc1_atomic", 32'(Atomic), 32'd1);
    tick();
    #1;
    check_val("sc2_atomic", 32'(Atomic), 32'd0);
    tick();
    Req_SC = 1'b0;

    // Matching invalidation kills the reservation
    run_load(32'h0000_2000, 1'b1, 32'h0000_0022, 1'b0, 1'b0);
    Inval_Valid   = 1'b1;
    Inval_Address = 30'h800;
    tick();
    Inval_Valid = 1'b0;
    Address     = 32'h0000_2000;
    Req_SC      = 1'b1;
    #1;
    check_val("inval_hit_atomic", 32'(Atomic), 32'd0);
    tick();
    Req_SC = 1'b0;

    // Non-matching invalidation leaves it intact
    run_load(32'h0000_2000, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
    Inval_Valid   = 1'b1;
    Inval_Address = 30'h801;
    tick();
    Inval_Valid = 1'b0;
    Address     = 32'h0000_2000;
    Req_SC      = 1'b1;
    #1;
    check_val("inval_miss_atomic", 32'(Atomic), 32'd1);
    tick();
    Req_SC = 1'b0;

    // ERET in the capture cycle wins
    run_load(32'h0000_2000, 1'b1, 32'h0000_0044, 1'b1, 1'b0);
    Address = 32'h0000_2000;
    #1;
    check_val("eret_cap_atomic", 32'(Atomic), 32'd0);

    // Invalidation of the in-flight LL word during WAIT
    run_load(32'h0000_2000, 1'b1, 32'h0000_0055, 1'b0, 1'b1);
    Address = 32'h0000_2000;
    #1;
    check_val("inval_wait_atomic", 32'(Atomic), 32'd0);

    // Plain LW does not arm a reservation
    run_load(32'h0000_2000, 1'b0, 32'h0000_0066, 1'b0, 1'b0);
    Address = 32'h0000_2000;
    #1;
    check_val("lw_no_res_atomic", 32'(Atomic), 32'd0);
    check_val("lw_no_res_rdata", ReadData, 32'h0000_0066);
`else
    // Without the reservation, Atomic is always 1
    run_load(32'h0000_2000, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    check_val("nollsc_rdata", ReadData, 32'h0000_0011);
    Address = 32'h0000_2000;
    Req_SC  = 1'b1;
    #1;
    check_val("nollsc_sc1", 32'(Atomic), 32'd1);
    tick();
    #1;
    check_val("nollsc_sc2", 32'(Atomic), 32'd1);
    Req_SC        = 1'b0;
    Inval_Valid   = 1'b1;
    Inval_Address = 30'h800;
    Eret          = 1'b1;
    tick();
    Inval_Valid = 1'b0;
    Eret        = 1'b0;
    Address     = 32'h0000_7FFC;
    #1;
    check_val("nollsc_after_clr", 32'(Atomic), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
